// File: rtl/rggen_rtl_pkg.sv
// Shared helpers for the register bit-field library: field bit positions and
// the width of the per-cycle event increment.
package rggen_rtl_pkg;

    // Count occupies the low bits of the field.
    function automatic int unsigned count_lsb();
        return 0;
    endfunction

    // Sticky overflow flag sits directly above the count.
    function automatic int unsigned overflow_bit(input int unsigned count_width);
        return count_width;
    endfunction

    // Bits needed to hold the number of asserted bits in an event vector.
    function automatic int unsigned popcount_width(input int unsigned event_width);
        return $clog2(event_width + 1);
    endfunction

endpackage

// File: rtl/rggen_bit_field_if.sv
// Register bit-field access bundle between the register block decoder and a
// single field implementation.
interface rggen_bit_field_if #(
    parameter int unsigned WIDTH = 9
);
    logic             read_valid;
    logic             write_valid;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] value;

    modport master (
        output read_valid,
        output write_valid,
        output mask,
        output write_data,
        input  read_data,
        input  value
    );

    modport bit_field (
        input  read_valid,
        input  write_valid,
        input  mask,
        input  write_data,
        output read_data,
        output value
    );
endinterface

// File: rtl/rggen_saturating_counter.sv
// Saturating up-counter: optional clear of the base, then add a multi-bit
// increment; results past all-ones pin the count and flag saturation.
module rggen_saturating_counter #(
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned INC_WIDTH   = 1
)(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   clear,
    input  logic [INC_WIDTH-1:0]   inc,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [COUNT_WIDTH-1:0] next_count,
    output logic                   saturated
);

    // Wide enough for both operands plus a carry, even when INC_WIDTH > COUNT_WIDTH.
    localparam int unsigned SUM_WIDTH =
        ((COUNT_WIDTH > INC_WIDTH) ? COUNT_WIDTH : INC_WIDTH) + 1;

    logic [COUNT_WIDTH-1:0] base;
    logic [SUM_WIDTH-1:0]   sum;

    // Clear zeroes the base so same-cycle events land in the post-clear value.
    always_comb begin
        base       = clear ? '0 : count;
        sum        = SUM_WIDTH'(base) + SUM_WIDTH'(inc);
        saturated  = |sum[SUM_WIDTH-1:COUNT_WIDTH];
        next_count = saturated ? '1 : sum[COUNT_WIDTH-1:0];
    end

    // Count register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/rggen_bit_field_event_counter.sv
// Event counter bit field: counts user event pulses, exposes {overflow, count}
// to software with read-clear and write-1-to-clear, plus a threshold flag.
module rggen_bit_field_event_counter
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned     COUNT_WIDTH = 8,
    parameter int unsigned     EVENT_WIDTH = 1,
    parameter longint unsigned THRESHOLD   = (64'd1 << COUNT_WIDTH) - 64'd1,
    parameter bit              READ_CLEAR  = 1'b1
)(
    input  logic                   i_clk,
    input  logic                   i_rst,
    rggen_bit_field_if.bit_field   bit_field_if,
    input  logic [EVENT_WIDTH-1:0] i_event,
    input  logic                   i_clear,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_overflow,
    output logic                   o_threshold
);

    localparam int unsigned INC_WIDTH    = popcount_width(EVENT_WIDTH);
    localparam int unsigned COUNT_POS    = count_lsb();
    localparam int unsigned OVERFLOW_POS = overflow_bit(COUNT_WIDTH);

    logic [INC_WIDTH-1:0]   inc;
    logic [COUNT_WIDTH-1:0] count_mask;
    logic [COUNT_WIDTH-1:0] count_wdata;
    logic                   rd_clr;
    logic                   wr_clr_cnt;
    logic                   wr_clr_ovf;
    logic                   clear_count;
    logic                   clear_ovf;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] next_count;
    logic                   saturated;
    logic                   overflow;
    logic                   threshold;

    // Number of event bits asserted this cycle.
    always_comb begin
        inc = '0;
        for (int unsigned i = 0; i < EVENT_WIDTH; i++) begin
            inc = inc + INC_WIDTH'(i_event[i]);
        end
    end

    // Software and hardware clear decode.
    always_comb begin
        count_mask  = bit_field_if.mask[COUNT_POS +: COUNT_WIDTH];
        count_wdata = bit_field_if.write_data[COUNT_POS +: COUNT_WIDTH];
        rd_clr      = READ_CLEAR && bit_field_if.read_valid && (|bit_field_if.mask);
        wr_clr_cnt  = bit_field_if.write_valid && (|count_mask)
                      && ((count_wdata & count_mask) == count_mask);
        wr_clr_ovf  = bit_field_if.write_valid && bit_field_if.mask[OVERFLOW_POS]
                      && bit_field_if.write_data[OVERFLOW_POS];
        clear_count = i_clear || rd_clr || wr_clr_cnt;
        clear_ovf   = i_clear || rd_clr || wr_clr_ovf;
    end

    rggen_saturating_counter #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .INC_WIDTH   (INC_WIDTH)
    ) u_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .clear      (clear_count),
        .inc        (inc),
        .count      (count),
        .next_count (next_count),
        .saturated  (saturated)
    );

    // Sticky overflow; saturation wins over a same-cycle clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            overflow <= 1'b0;
        end else if (saturated) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Threshold flag tracks the value the count register is about to take.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            threshold <= 1'b0;
        end else begin
            threshold <= (64'(next_count) >= THRESHOLD);
        end
    end

    assign bit_field_if.read_data = {overflow, count};
    assign bit_field_if.value     = {overflow, count};
    assign o_count                = count;
    assign o_overflow             = overflow;
    assign o_threshold            = threshold;

endmodule

// File: tb/tb_rggen_bit_field_event_counter.sv
// Self-checking bench for rggen_bit_field_event_counter: three configurations
// driven by directed and random stimulus against an arithmetic reference model.
module tb_rggen_bit_field_event_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // A: 8-bit count, 4 events, threshold 100, read-clear
    // B: 4-bit count, 1 event, threshold 3, read-clear
    // C: same as A but READ_CLEAR=0, shares A's stimulus
    logic [3:0] ev_a = '0;
    logic       ev_b = 1'b0;
    logic       clr_a = 1'b0;
    logic       clr_b = 1'b0;

    logic [7:0] a_count, c_count;
    logic [3:0] b_count;
    logic       a_ovf, b_ovf, c_ovf, a_thr, b_thr, c_thr;

    rggen_bit_field_if #(.WIDTH(9)) ifa ();
    rggen_bit_field_if #(.WIDTH(5)) ifb ();
    rggen_bit_field_if #(.WIDTH(9)) ifc ();

    rggen_bit_field_event_counter #(
        .COUNT_WIDTH (8), .EVENT_WIDTH (4), .THRESHOLD (100), .READ_CLEAR (1'b1)
    ) dut_a (
        .i_clk (clk), .i_rst (rst), .bit_field_if (ifa), .i_event (ev_a),
        .i_clear (clr_a), .o_count (a_count), .o_overflow (a_ovf), .o_threshold (a_thr)
    );

    rggen_bit_field_event_counter #(
        .COUNT_WIDTH (4), .EVENT_WIDTH (1), .THRESHOLD (3), .READ_CLEAR (1'b1)
    ) dut_b (
        .i_clk (clk), .i_rst (rst), .bit_field_if (ifb), .i_event (ev_b),
        .i_clear (clr_b), .o_count (b_count), .o_overflow (b_ovf), .o_threshold (b_thr)
    );

    rggen_bit_field_event_counter #(
        .COUNT_WIDTH (8), .EVENT_WIDTH (4), .THRESHOLD (100), .READ_CLEAR (1'b0)
    ) dut_c (
        .i_clk (clk), .i_rst (rst), .bit_field_if (ifc), .i_event (ev_a),
        .i_clear (clr_a), .o_count (c_count), .o_overflow (c_ovf), .o_threshold (c_thr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    int unsigned m_ca = 0, m_cb = 0, m_cc = 0;
    bit          m_oa = 0, m_ob = 0, m_oc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of the counter rules, in plain integer arithmetic.
    task automatic model_step(input int unsigned cw, input bit rc, input int unsigned pop,
                              input bit clr, input bit rv, input bit wv,
                              input logic [31:0] mask, input logic [31:0] wdata,
                              inout int unsigned cnt, inout bit ovf);
        int unsigned max_v, cmask, base, sum;
        bit rd, wcc, wco;
        max_v = (32'd1 << cw) - 1;
        cmask = mask & max_v;
        rd    = rc && rv && (mask != 0);
        wcc   = wv && (cmask != 0) && ((wdata & cmask) == cmask);
        wco   = wv && mask[cw] && wdata[cw];
        base  = (clr || rd || wcc) ? 0 : cnt;
        sum   = base + pop;
        if (sum > max_v) begin
            cnt = max_v;
            ovf = 1'b1;
        end else begin
            cnt = sum;
            if (clr || rd || wco) ovf = 1'b0;
        end
    endtask

    task automatic set_bus_a(input bit rv, input bit wv, input logic [8:0] m, input logic [8:0] wd);
        ifa.read_valid = rv; ifa.write_valid = wv; ifa.mask = m; ifa.write_data = wd;
        ifc.read_valid = rv; ifc.write_valid = wv; ifc.mask = m; ifc.write_data = wd;
    endtask

    task automatic set_bus_b(input bit rv, input bit wv, input logic [4:0] m, input logic [4:0] wd);
        ifb.read_valid = rv; ifb.write_valid = wv; ifb.mask = m; ifb.write_data = wd;
    endtask

    // Check pre-edge read data, advance the model with the applied inputs,
    // clock once, then check the registered outputs.
    task automatic cycle();
        check("A.read_data", 64'(ifa.read_data), 64'({m_oa, m_ca[7:0]}));
        check("B.read_data", 64'(ifb.read_data), 64'({m_ob, m_cb[3:0]}));
        check("C.read_data", 64'(ifc.read_data), 64'({m_oc, m_cc[7:0]}));
        model_step(8, 1'b1, $countones(ev_a), clr_a, ifa.read_valid, ifa.write_valid,
                   32'(ifa.mask), 32'(ifa.write_data), m_ca, m_oa);
        model_step(4, 1'b1, $countones(ev_b), clr_b, ifb.read_valid, ifb.write_valid,
                   32'(ifb.mask), 32'(ifb.write_data), m_cb, m_ob);
        model_step(8, 1'b0, $countones(ev_a), clr_a, ifc.read_valid, ifc.write_valid,
                   32'(ifc.mask), 32'(ifc.write_data), m_cc, m_oc);
        @(posedge clk);
        #1;
        check("A.count", 64'(a_count), 64'(m_ca));
        check("A.overflow", 64'(a_ovf), 64'(m_oa));
        check("A.threshold", 64'(a_thr), 64'(m_ca >= 100));
        check("B.count", 64'(b_count), 64'(m_cb));
        check("B.overflow", 64'(b_ovf), 64'(m_ob));
        check("B.threshold", 64'(b_thr), 64'(m_cb >= 3));
        check("C.count", 64'(c_count), 64'(m_cc));
        check("C.overflow", 64'(c_ovf), 64'(m_oc));
        check("C.threshold", 64'(c_thr), 64'(m_cc >= 100));
    endtask

    initial begin
        logic [8:0] ma, wa;
        logic [4:0] mb, wb;
        int unsigned r;

        set_bus_a(1'b0, 1'b0, '0, '0);
        set_bus_b(1'b0, 1'b0, '0, '0);

        // Reset state
        #12;
        check("rst.A.count", 64'(a_count), 64'd0);
        check("rst.A.read_data", 64'(ifa.read_data), 64'd0);
        check("rst.B.count", 64'(b_count), 64'd0);
        check("rst.B.overflow", 64'(b_ovf), 64'd0);
        check("rst.B.threshold", 64'(b_thr), 64'd0);
        check("rst.C.value", 64'(ifc.value), 64'd0);
        rst = 1'b0;

        // B: 5 single events; A: 4'b1011 for 3 cycles
        for (int k = 0; k < 5; k++) begin
            ev_b = 1'b1;
            ev_a = (k < 3) ? 4'b1011 : 4'b0000;
            cycle();
        end
        ev_b = 1'b0;
        ev_a = '0;
        check("B.five_events", 64'(b_count), 64'd5);
        check("B.five_read_data", 64'(ifb.read_data), 64'h05);
        check("B.five_overflow", 64'(b_ovf), 64'd0);
        check("A.popcount_sum", 64'(a_count), 64'd9);

        // A: read-clear with a coincident event; C keeps counting
        set_bus_a(1'b1, 1'b0, '1, '0);
        ev_a = 4'b0001;
        check("A.read_returns_9", 64'(ifa.read_data), 64'h009);
        cycle();
        set_bus_a(1'b0, 1'b0, '0, '0);
        ev_a = '0;
        check("A.after_read_clear", 64'(a_count), 64'd1);
        check("C.no_read_clear", 64'(c_count), 64'd10);

        // B: hardware clear drops count and threshold
        clr_b = 1'b1;
        cycle();
        clr_b = 1'b0;
        check("B.clear_count", 64'(b_count), 64'd0);
        check("B.clear_threshold", 64'(b_thr), 64'd0);

        // B: saturate, then write-1 to overflow bit only
        ev_b = 1'b1;
        for (int k = 0; k < 18; k++) cycle();
        ev_b = 1'b0;
        check("B.sat_count", 64'(b_count), 64'd15);
        check("B.sat_overflow", 64'(b_ovf), 64'd1);
        set_bus_b(1'b0, 1'b1, 5'h10, 5'h10);
        cycle();
        set_bus_b(1'b0, 1'b0, '0, '0);
        check("B.w1c_ovf_count", 64'(b_count), 64'd15);
        check("B.w1c_ovf_flag", 64'(b_ovf), 64'd0);

        // A/C: write-1-to-clear on count bits
        set_bus_a(1'b0, 1'b1, 9'h0FF, 9'h0FF);
        cycle();
        set_bus_a(1'b0, 1'b0, '0, '0);
        check("A.w1c_count", 64'(a_count), 64'd0);
        check("C.w1c_count", 64'(c_count), 64'd0);

        // Random events only: drives all counters into saturation
        for (int i = 0; i < 150; i++) begin
            ev_a = 4'($urandom);
            ev_b = 1'($urandom);
            cycle();
        end

        // Random mixed events, clears, reads and writes
        for (int i = 0; i < 250; i++) begin
            ev_a  = 4'($urandom);
            ev_b  = 1'($urandom);
            clr_a = ($urandom_range(0, 15) == 0);
            clr_b = ($urandom_range(0, 15) == 0);
            r  = $urandom_range(0, 7);
            ma = ($urandom_range(0, 1) == 1) ? 9'h1FF : 9'($urandom);
            wa = ($urandom_range(0, 1) == 1) ? (9'($urandom) | ma) : 9'($urandom);
            set_bus_a(r == 0, r == 1, ma, wa);
            r  = $urandom_range(0, 7);
            mb = ($urandom_range(0, 1) == 1) ? 5'h1F : 5'($urandom);
            wb = ($urandom_range(0, 1) == 1) ? (5'($urandom) | mb) : 5'($urandom);
            set_bus_b(r == 0, r == 1, mb, wb);
            cycle();
        end
        ev_a = '0; ev_b = 1'b0; clr_a = 1'b0;
        set_bus_a(1'b0, 1'b0, '0, '0);
        set_bus_b(1'b0, 1'b0, '0, '0);

        // B to 6, then asynchronous reset between edges
        clr_b = 1'b1;
        cycle();
        clr_b = 1'b0;
        ev_b = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        ev_b = 1'b0;
        check("B.six_before_reset", 64'(b_count), 64'd6);
        #3;
        rst = 1'b1;
        #1;
        check("async.B.count", 64'(b_count), 64'd0);
        check("async.B.read_data", 64'(ifb.read_data), 64'd0);
        check("async.B.threshold", 64'(b_thr), 64'd0);
        check("async.A.count", 64'(a_count), 64'd0);
        check("async.A.overflow", 64'(a_ovf), 64'd0);
        m_ca = 0; m_cb = 0; m_cc = 0;
        m_oa = 0; m_ob = 0; m_oc = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ev_b = 1'b1;
        cycle();
        ev_b = 1'b0;
        check("B.resume_count", 64'(b_count), 64'd1);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
